// File: rtl/fp_normalize.sv
// fp_normalize: post-add normalization for the single-precision adder.
// Two-stage valid/ready pipeline. Stage 1 registers the raw sum and its
// leading-zero count. Stage 2 shifts the mantissa, adjusts the exponent,
// saturates or flushes the result, and packs the IEEE-754 word.
module fp_normalize (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_sign,
    input  logic [7:0]  i_exp,
    input  logic [25:0] i_mant,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_result,
    output logic        o_overflow,
    output logic        o_underflow
);

    // Stage 1 state
    logic        s1_valid_q, s1_valid_d;
    logic        s1_sign_q,  s1_sign_d;
    logic [7:0]  s1_exp_q,   s1_exp_d;
    logic [25:0] s1_mant_q,  s1_mant_d;
    logic [4:0]  s1_lz_q,    s1_lz_d;

    // Stage 2 (output) state
    logic        o_valid_q,  o_valid_d;
    logic [31:0] result_q,   result_d;
    logic        ovf_q,      ovf_d;
    logic        unf_q,      unf_d;

    logic        adv2;
    logic        adv1;
    logic [4:0]  in_lz;

    logic [4:0]        sh;
    logic [25:0]       m_norm;
    logic signed [9:0] e_norm;
    logic [22:0]       frac;
    logic [31:0]       packed_res;
    logic              packed_ovf;
    logic              packed_unf;

    // Flow control: a stage moves when its downstream slot is free or draining.
    // o_ready is the only combinational input-to-output path (from i_ready).
    always_comb begin
        adv2    = !o_valid_q || i_ready;
        adv1    = !s1_valid_q || adv2;
        o_ready = adv1;
    end

    // Leading-zero count from bit 25; the highest set bit wins, 26 when zero.
    always_comb begin
        in_lz = 5'd26;
        for (int i = 0; i < 26; i++) begin
            if (i_mant[i]) in_lz = 5'(25 - i);
        end
    end

    // Stage 1 next state: capture the input word whenever the stage advances.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_mant_d  = s1_mant_q;
        s1_lz_d    = s1_lz_q;
        if (adv1) begin
            s1_valid_d = i_valid;
            if (i_valid) begin
                s1_sign_d = i_sign;
                s1_exp_d  = i_exp;
                s1_mant_d = i_mant;
                s1_lz_d   = in_lz;
            end
        end
    end

    // Normalize the stage-1 word: right shift on carry, left shift after cancellation.
    always_comb begin
        sh     = 5'd0;
        m_norm = s1_mant_q >> 1;
        e_norm = $signed({2'b00, s1_exp_q}) + 10'sd1;
        if (s1_lz_q != 5'd0) begin
            sh     = s1_lz_q - 5'd1;
            m_norm = s1_mant_q << sh;
            e_norm = $signed({2'b00, s1_exp_q}) - $signed({5'b00000, sh});
        end
        // Fraction sits in m[23:1]; the guard bit is simply dropped.
        frac = 23'(m_norm >> 1);

        packed_ovf = 1'b0;
        packed_unf = 1'b0;
        if (s1_mant_q == 26'd0) begin
            packed_res = {s1_sign_q, 31'd0};
        end else if (e_norm >= 10'sd255) begin
            packed_res = {s1_sign_q, 8'hFF, 23'd0};
            packed_ovf = 1'b1;
        end else if (e_norm <= 10'sd0) begin
            packed_res = {s1_sign_q, 31'd0};
            packed_unf = 1'b1;
        end else begin
            packed_res = {s1_sign_q, e_norm[7:0], frac};
        end
    end

    // Stage 2 next state: load the packed result when the output slot advances.
    always_comb begin
        o_valid_d = o_valid_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        if (adv2) begin
            o_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = packed_res;
                ovf_d    = packed_ovf;
                unf_d    = packed_unf;
            end
        end
    end

    // Pipeline registers; reset empties both stages and clears the outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= 8'd0;
            s1_mant_q  <= 26'd0;
            s1_lz_q    <= 5'd0;
            o_valid_q  <= 1'b0;
            result_q   <= 32'd0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_exp_q   <= s1_exp_d;
            s1_mant_q  <= s1_mant_d;
            s1_lz_q    <= s1_lz_d;
            o_valid_q  <= o_valid_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Output drive
    always_comb begin
        o_valid     = o_valid_q;
        o_result    = result_q;
        o_overflow  = ovf_q;
        o_underflow = unf_q;
    end

endmodule

// File: tb/tb_fp_normalize.sv
// Self-checking bench for fp_normalize: directed cases, backpressure,
// mid-stream reset and a random stream, all checked through a scoreboard.
module tb_fp_normalize;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic        i_sign;
    logic [7:0]  i_exp;
    logic [25:0] i_mant;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_overflow;
    logic        o_underflow;

    int checks = 0;
    int errors = 0;
    int n_in   = 0;
    int n_out  = 0;
    bit rand_ready = 0;

    // Expected {overflow, underflow, result}, pushed on accept.
    logic [33:0] sb[$];

    fp_normalize dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_sign      (i_sign),
        .i_exp       (i_exp),
        .i_mant      (i_mant),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: locate the leading one, then place it at bit 24.
    function automatic logic [33:0] model(input logic s, input logic [7:0] e, input logic [25:0] m);
        int p = -1;
        int ex;
        logic [25:0] mn;
        for (int i = 0; i < 26; i++) if (m[i]) p = i;
        if (p < 0) return {2'b00, s, 31'd0};
        ex = int'(e) + p - 24;
        if (p == 25) mn = m >> 1;
        else         mn = m << (24 - p);
        if (ex >= 255) return {2'b10, s, 8'hFF, 23'd0};
        if (ex <= 0)   return {2'b01, s, 31'd0};
        return {2'b00, s, 8'(ex), mn[23:1]};
    endfunction

    // Scoreboard monitor: handshakes are sampled mid-cycle and take effect at the next edge.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 64'(o_result), 64'hDEAD_0000);
                end else begin
                    check("result", 64'({o_overflow, o_underflow, o_result}), 64'(sb.pop_front()));
                    n_out++;
                end
            end
            if (i_valid && o_ready) begin
                sb.push_back(model(i_sign, i_exp, i_mant));
                n_in++;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
            if (rand_ready) i_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send(input logic s, input logic [7:0] e, input logic [25:0] m);
        bit acc;
        int n;
        i_valid = 1'b1;
        i_sign  = s;
        i_exp   = e;
        i_mant  = m;
        n = 0;
        do begin
            @(negedge i_clk);
            acc = o_ready;
            @(posedge i_clk);
            #1;
            if (rand_ready) i_ready = 1'($urandom_range(0, 1));
            n++;
        end while (!acc && n < 1000);
        if (!acc) check("send_timeout", 64'(acc), 64'd1);
        i_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_sign  = 1'b0;
        i_exp   = 8'd0;
        i_mant  = 26'd0;
        i_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_o_ready", 64'(o_ready), 64'd1);
        check("rst_o_result", 64'(o_result), 64'd0);
        check("rst_flags", 64'({o_overflow, o_underflow}), 64'd0);
        i_rst_n = 1'b1;
        cycles(2);

        // Carry case with latency: accepted at edge N, valid after edge N+1
        send(1'b0, 8'h7F, 26'h2000000);
        check("lat_edge_n", 64'(o_valid), 64'd0);
        @(posedge i_clk);
        #1;
        check("lat_edge_n1", 64'(o_valid), 64'd1);
        check("carry_result", 64'(o_result), 64'h4000_0000);
        check("carry_flags", 64'({o_overflow, o_underflow}), 64'd0);

        // Normalized, zero, cancellation, overflow, underflow back to back
        send(1'b0, 8'h7F, 26'h1000000);
        send(1'b1, 8'h7F, 26'h0000000);
        send(1'b0, 8'h7F, 26'h0000002);
        send(1'b0, 8'hFE, 26'h2000000);
        send(1'b0, 8'h03, 26'h0000002);
        cycles(4);
        check("directed_drain", 64'(sb.size()), 64'd0);

        // Backpressure: three words offered with i_ready low, only two fit
        i_ready = 1'b0;
        base = n_in;
        send(1'b0, 8'h80, 26'h1800000);
        send(1'b1, 8'h40, 26'h0400001);
        i_valid = 1'b1;
        i_sign  = 1'b0;
        i_exp   = 8'h90;
        i_mant  = 26'h2A00000;
        cycles(3);
        check("bp_o_ready_low", 64'(o_ready), 64'd0);
        check("bp_accepted", 64'(n_in - base), 64'd2);
        i_ready = 1'b1;
        #1;
        check("bp_o_ready_rise", 64'(o_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            check("bp_no_gap", 64'(o_valid), 64'd1);
            @(posedge i_clk);
            #1;
            i_valid = 1'b0;
        end
        cycles(2);
        check("bp_drain", 64'(sb.size()), 64'd0);
        check("bp_count", 64'(n_out), 64'(n_in));

        // Reset mid-stream with both stages full
        i_ready = 1'b0;
        send(1'b0, 8'h7F, 26'h1000000);
        send(1'b0, 8'h7E, 26'h1000000);
        cycles(1);
        check("mid_full_ready", 64'(o_ready), 64'd0);
        #3;
        i_rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_o_valid", 64'(o_valid), 64'd0);
        check("mid_rst_o_result", 64'(o_result), 64'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        check("mid_rel_o_ready", 64'(o_ready), 64'd1);
        cycles(10);
        check("mid_no_stale", 64'(o_valid), 64'd0);

        // Random stream under random backpressure
        rand_ready = 1;
        for (int k = 0; k < 200; k++) begin
            logic [25:0] m;
            m = 26'($urandom) >> $urandom_range(0, 26);
            send(1'($urandom_range(0, 1)), 8'($urandom), m);
            if ($urandom_range(0, 3) == 0) cycles(1);
        end
        rand_ready = 0;
        i_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            cycles(1);
            n++;
        end
        check("random_drain", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
